// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - MM register bus and Avalon-ST video source signals
interface video_pattern_gen_if;
    logic        s_chipselect;
    logic        s_read;
    logic        s_write;
    logic [2:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;

    // Generator side: MM slave and streaming source
    modport master (
        input  s_chipselect, s_read, s_write, s_address, s_writedata, source_ready,
        output s_readdata, source_data, source_valid, source_sop, source_eop
    );

    // Host/sink side
    modport slave (
        output s_chipselect, s_read, s_write, s_address, s_writedata, source_ready,
        input  s_readdata, source_data, source_valid, source_sop, source_eop
    );
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - Avalon-ST video test pattern source with MM control registers
module video_pattern_gen #(
    parameter int          IMAGE_W = 640,
    parameter int          IMAGE_H = 480,
    parameter logic [31:0] ID_WORD = 32'h1234EEE3
) (
    input  logic                clk,
    input  logic                reset,
    video_pattern_gen_if.master bus
);
    localparam logic [15:0] W16   = 16'(IMAGE_W);
    localparam logic [15:0] H16   = 16'(IMAGE_H);
    localparam logic [15:0] BAR_W = 16'(IMAGE_W / 8);
    // Control packet: width/height nibbles, three per beat, MS nibble first
    localparam logic [23:0] CTL_BEAT0 = {4'h0, W16[7:4],   4'h0, W16[11:8],  4'h0, W16[15:12]};
    localparam logic [23:0] CTL_BEAT1 = {4'h0, H16[11:8],  4'h0, H16[15:12], 4'h0, W16[3:0]};
    localparam logic [23:0] CTL_BEAT2 = {4'h0, 4'h0,       4'h0, H16[3:0],   4'h0, H16[7:4]};

    typedef enum logic [2:0] {S_IDLE, S_CTL_HDR, S_CTL_BODY, S_VID_HDR, S_PIXELS} state_t;

    // Live registers
    logic        r_enable, r_ctl_en;
    logic [1:0]  r_pattern;
    logic [23:0] r_solid, r_boxcol;
    logic [7:0]  r_box_size, r_box_step;
    logic [31:0] r_readdata;
    logic [31:0] w_rd_mux;

    // Per-frame snapshot
    logic [1:0]  r_s_pattern;
    logic [23:0] r_s_solid, r_s_boxcol;
    logic [7:0]  r_s_size, r_s_step;

    // Sequencer state and registered stream outputs
    state_t      r_state;
    logic [1:0]  r_ctl_cnt;
    logic [15:0] r_x, r_y, r_bar_cnt;
    logic [2:0]  r_bar;
    logic [15:0] r_frames;
    logic [15:0] r_box_x, r_box_y;
    logic        r_dir_x, r_dir_y;
    logic [23:0] r_data;
    logic        r_valid, r_sop, r_eop;

    logic [15:0] w_nx, w_ny, w_nbar_cnt;
    logic [2:0]  w_nbar;
    logic        w_last_next;
    logic [23:0] w_bar_col, w_pix;
    logic        w_in_box;
    logic [16:0] w_sum_x, w_sum_y;
    logic [15:0] w_nbox_x, w_nbox_y;
    logic        w_ndir_x, w_ndir_y;

    assign bus.source_data  = r_data;
    assign bus.source_valid = r_valid;
    assign bus.source_sop   = r_sop;
    assign bus.source_eop   = r_eop;
    assign bus.s_readdata   = r_readdata;

    // Read-back multiplexer
    always_comb begin
        w_rd_mux = '0;
        case (bus.s_address)
            3'd0:    w_rd_mux = {27'b0, r_ctl_en, 1'b0, r_pattern, r_enable};
            3'd1:    w_rd_mux = {8'b0, r_solid};
            3'd2:    w_rd_mux = {8'b0, r_boxcol};
            3'd3:    w_rd_mux = {16'b0, r_box_step, r_box_size};
            3'd4:    w_rd_mux = {16'b0, r_frames};
            3'd5:    w_rd_mux = ID_WORD;
            default: w_rd_mux = '0;
        endcase
    end

    // Register writes and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_pattern  <= 2'd0;
            r_ctl_en   <= 1'b0;
            r_solid    <= '0;
            r_boxcol   <= 24'hFF0000;
            r_box_size <= 8'd16;
            r_box_step <= 8'd4;
            r_readdata <= '0;
        end else begin
            if (bus.s_chipselect && bus.s_write) begin
                case (bus.s_address)
                    3'd0: begin
                        r_enable  <= bus.s_writedata[0];
                        r_pattern <= bus.s_writedata[2:1];
                        r_ctl_en  <= bus.s_writedata[4];
                    end
                    3'd1: r_solid  <= bus.s_writedata[23:0];
                    3'd2: r_boxcol <= bus.s_writedata[23:0];
                    3'd3: begin
                        r_box_size <= bus.s_writedata[7:0];
                        r_box_step <= bus.s_writedata[15:8];
                    end
                    default: ;
                endcase
            end
            if (bus.s_chipselect && bus.s_read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    // Next raster position and bar index; outside PIXELS this is pixel (0,0)
    always_comb begin
        w_nx       = '0;
        w_ny       = '0;
        w_nbar     = '0;
        w_nbar_cnt = '0;
        if (r_state == S_PIXELS) begin
            if (r_x == W16 - 16'd1) begin
                w_ny = r_y + 16'd1;
            end else begin
                w_nx = r_x + 16'd1;
                w_ny = r_y;
                if (r_bar_cnt == BAR_W - 16'd1) begin
                    w_nbar = r_bar + 3'd1;
                end else begin
                    w_nbar     = r_bar;
                    w_nbar_cnt = r_bar_cnt + 16'd1;
                end
            end
        end
        w_last_next = (w_nx == W16 - 16'd1) && (w_ny == H16 - 16'd1);
    end

    // Colour of the next pixel from the frame snapshot
    always_comb begin
        case (w_nbar)
            3'd0:    w_bar_col = 24'hFFFFFF;
            3'd1:    w_bar_col = 24'hFFFF00;
            3'd2:    w_bar_col = 24'h00FFFF;
            3'd3:    w_bar_col = 24'h00FF00;
            3'd4:    w_bar_col = 24'hFF00FF;
            3'd5:    w_bar_col = 24'hFF0000;
            3'd6:    w_bar_col = 24'h0000FF;
            default: w_bar_col = 24'h000000;
        endcase
        w_in_box = ({1'b0, w_nx} >= {1'b0, r_box_x}) &&
                   ({1'b0, w_nx} <  {1'b0, r_box_x} + {9'b0, r_s_size}) &&
                   ({1'b0, w_ny} >= {1'b0, r_box_y}) &&
                   ({1'b0, w_ny} <  {1'b0, r_box_y} + {9'b0, r_s_size});
        case (r_s_pattern)
            2'd1:    w_pix = r_s_solid;
            2'd2:    w_pix = w_in_box ? r_s_boxcol : 24'h000000;
            default: w_pix = w_bar_col;
        endcase
    end

    // Box bounce: reverse before crossing the far edge or going below zero
    always_comb begin
        w_sum_x = {1'b0, r_box_x} + {9'b0, r_s_step} + {9'b0, r_s_size};
        w_sum_y = {1'b0, r_box_y} + {9'b0, r_s_step} + {9'b0, r_s_size};
        if (!r_dir_x && (w_sum_x > {1'b0, W16})) begin
            w_nbox_x = r_box_x - {8'b0, r_s_step};
            w_ndir_x = 1'b1;
        end else if (r_dir_x && (r_box_x < {8'b0, r_s_step})) begin
            w_nbox_x = r_box_x + {8'b0, r_s_step};
            w_ndir_x = 1'b0;
        end else begin
            w_nbox_x = r_dir_x ? r_box_x - {8'b0, r_s_step} : r_box_x + {8'b0, r_s_step};
            w_ndir_x = r_dir_x;
        end
        if (!r_dir_y && (w_sum_y > {1'b0, H16})) begin
            w_nbox_y = r_box_y - {8'b0, r_s_step};
            w_ndir_y = 1'b1;
        end else if (r_dir_y && (r_box_y < {8'b0, r_s_step})) begin
            w_nbox_y = r_box_y + {8'b0, r_s_step};
            w_ndir_y = 1'b0;
        end else begin
            w_nbox_y = r_dir_y ? r_box_y - {8'b0, r_s_step} : r_box_y + {8'b0, r_s_step};
            w_ndir_y = r_dir_y;
        end
    end

    // Frame sequencer; outputs always hold the beat currently offered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_data      <= '0;
            r_ctl_cnt   <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_bar       <= '0;
            r_bar_cnt   <= '0;
            r_frames    <= '0;
            r_box_x     <= '0;
            r_box_y     <= '0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_s_pattern <= '0;
            r_s_solid   <= '0;
            r_s_boxcol  <= '0;
            r_s_size    <= '0;
            r_s_step    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_enable) begin
                        r_s_pattern <= r_pattern;
                        r_s_solid   <= r_solid;
                        r_s_boxcol  <= r_boxcol;
                        r_s_size    <= r_box_size;
                        r_s_step    <= r_box_step;
                        r_valid     <= 1'b1;
                        r_sop       <= 1'b1;
                        r_eop       <= 1'b0;
                        r_state     <= r_ctl_en ? S_CTL_HDR : S_VID_HDR;
                        r_data      <= r_ctl_en ? 24'h00000F : 24'h000000;
                    end
                end
                S_CTL_HDR: begin
                    if (bus.source_ready) begin
                        r_state   <= S_CTL_BODY;
                        r_ctl_cnt <= 2'd0;
                        r_sop     <= 1'b0;
                        r_data    <= CTL_BEAT0;
                    end
                end
                S_CTL_BODY: begin
                    if (bus.source_ready) begin
                        if (r_ctl_cnt == 2'd2) begin
                            r_state <= S_VID_HDR;
                            r_sop   <= 1'b1;
                            r_eop   <= 1'b0;
                            r_data  <= 24'h000000;
                        end else begin
                            r_ctl_cnt <= r_ctl_cnt + 2'd1;
                            r_eop     <= (r_ctl_cnt == 2'd1);
                            r_data    <= (r_ctl_cnt == 2'd0) ? CTL_BEAT1 : CTL_BEAT2;
                        end
                    end
                end
                S_VID_HDR: begin
                    if (bus.source_ready) begin
                        r_state   <= S_PIXELS;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_bar     <= '0;
                        r_bar_cnt <= '0;
                        r_sop     <= 1'b0;
                        r_eop     <= w_last_next;
                        r_data    <= w_pix;
                    end
                end
                default: begin
                    if (bus.source_ready) begin
                        if (r_eop) begin
                            r_state  <= S_IDLE;
                            r_valid  <= 1'b0;
                            r_eop    <= 1'b0;
                            r_data   <= '0;
                            r_frames <= r_frames + 16'd1;
                            r_box_x  <= w_nbox_x;
                            r_box_y  <= w_nbox_y;
                            r_dir_x  <= w_ndir_x;
                            r_dir_y  <= w_ndir_y;
                        end else begin
                            r_x       <= w_nx;
                            r_y       <= w_ny;
                            r_bar     <= w_nbar;
                            r_bar_cnt <= w_nbar_cnt;
                            r_eop     <= w_last_next;
                            r_data    <= w_pix;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - randomized self-checking bench for video_pattern_gen
module tb_video_pattern_gen;
    localparam int          W  = 32;
    localparam int          H  = 24;
    localparam logic [31:0] ID = 32'hCAFE0042;

    logic clk = 1'b0;
    logic reset = 1'b1;
    video_pattern_gen_if bus();

    video_pattern_gen #(.IMAGE_W(W), .IMAGE_H(H), .ID_WORD(ID)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Bench-side register shadow and per-frame snapshot
    bit          sh_en, sh_ctl;
    logic [1:0]  sh_pat;
    logic [23:0] sh_solid, sh_boxcol;
    int          sh_size, sh_step;
    bit          fr_ctl;
    logic [1:0]  fr_pat;
    logic [23:0] fr_solid, fr_boxcol;
    int          fr_size, fr_step, fr_bx, fr_by;

    // Model state
    int  box_x, box_y, frames_model, n_starts, beat_idx, gap, bp_mode;
    bit  dir_x, dir_y, in_frame, gap_arm, just_reset, prev_stall, prev_sop, prev_eop;
    logic [23:0] prev_data;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Log of the most recent frame, for literal checks
    logic [23:0] lg_data [16];
    bit          lg_sop [16];
    bit          lg_eop [16];
    logic [23:0] lg_last, lg_boxin, lg_boxout;
    bit          lg_boxout_ok;
    int          lg_eops;
    int          hist_x [64];
    int          hist_y [64];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        chk(act === req, name, act, req);
    endtask

    function automatic logic [23:0] exp_pixel(input int x, input int y);
        if (fr_pat == 2'd1) return fr_solid;
        if (fr_pat == 2'd2)
            return (x >= fr_bx && x < fr_bx + fr_size && y >= fr_by && y < fr_by + fr_size) ? fr_boxcol : 24'h0;
        return bars[x / (W / 8)];
    endfunction

    function automatic int frame_len();
        return (fr_ctl ? 5 : 1) + W * H;
    endfunction

    // {sop, eop, data} of beat k of the current frame
    function automatic logic [25:0] exp_beat(input int k);
        logic [31:0] wh;
        logic [3:0]  n [9];
        int          p, b;
        if (fr_ctl) begin
            if (k == 0) return {2'b10, 24'h00000F};
            if (k == 4) return {2'b10, 24'h000000};
            if (k <= 3) begin
                wh = {16'(W), 16'(H)};
                for (int i = 0; i < 8; i++) n[i] = 4'((wh >> (28 - 4 * i)) & 32'hF);
                n[8] = 4'h0;
                b = 3 * (k - 1);
                return {1'b0, (k == 3), 4'h0, n[b + 2], 4'h0, n[b + 1], 4'h0, n[b]};
            end
            p = k - 5;
        end else begin
            if (k == 0) return {2'b10, 24'h000000};
            p = k - 1;
        end
        return {1'b0, (p == W * H - 1), exp_pixel(p % W, p / W)};
    endfunction

    function automatic void step_axis(inout int pos, inout bit dir, input int lim);
        if (!dir && pos + fr_step + fr_size > lim) begin
            dir = 1'b1;
            pos = pos - fr_step;
        end else if (dir && pos < fr_step) begin
            dir = 1'b0;
            pos = pos + fr_step;
        end else begin
            pos = dir ? pos - fr_step : pos + fr_step;
        end
    endfunction

    // Compare process: samples 2 ns before each rising edge
    initial begin
        logic [25:0] e;
        int p;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                in_frame = 0; beat_idx = 0; prev_stall = 0; gap_arm = 0;
                box_x = 0; box_y = 0; dir_x = 0; dir_y = 0; frames_model = 0;
                just_reset = 1;
            end else begin
                if (just_reset) begin
                    chk_eq("valid_after_reset", 32'(bus.source_valid), 32'd0);
                    just_reset = 0;
                end
                if (prev_stall)
                    chk(bus.source_valid && bus.source_data == prev_data && bus.source_sop == prev_sop &&
                        bus.source_eop == prev_eop, "stall_stable",
                        {7'b0, bus.source_valid, bus.source_data}, {8'h01, prev_data});
                if (in_frame && bp_mode == 0)
                    chk_eq("no_bubble", 32'(bus.source_valid), 32'd1);
                if (!in_frame) begin
                    if (bus.source_valid) begin
                        chk_eq("frame_start_enabled", 32'(sh_en), 32'd1);
                        if (gap_arm) chk_eq("idle_gap", gap, 32'd1);
                        gap_arm = 0;
                        fr_ctl = sh_ctl; fr_pat = sh_pat; fr_solid = sh_solid; fr_boxcol = sh_boxcol;
                        fr_size = sh_size; fr_step = sh_step; fr_bx = box_x; fr_by = box_y;
                        if (frames_model < 64) begin
                            hist_x[frames_model] = box_x;
                            hist_y[frames_model] = box_y;
                        end
                        in_frame = 1; beat_idx = 0; lg_eops = 0; lg_boxout_ok = 0;
                        n_starts++;
                    end else begin
                        gap++;
                    end
                end
                if (in_frame && bus.source_valid && bus.source_ready) begin
                    e = exp_beat(beat_idx);
                    chk_eq($sformatf("beat%0d", beat_idx),
                           {6'b0, bus.source_sop, bus.source_eop, bus.source_data}, {6'b0, e});
                    if (beat_idx < 16) begin
                        lg_data[beat_idx] = bus.source_data;
                        lg_sop[beat_idx]  = bus.source_sop;
                        lg_eop[beat_idx]  = bus.source_eop;
                    end
                    p = beat_idx - (fr_ctl ? 5 : 1);
                    if (p >= 0) begin
                        if (p % W == fr_bx && p / W == fr_by) lg_boxin = bus.source_data;
                        if (p % W == fr_bx + fr_size && p / W == fr_by) begin
                            lg_boxout = bus.source_data;
                            lg_boxout_ok = 1;
                        end
                    end
                    if (bus.source_eop) lg_eops++;
                    lg_last = bus.source_data;
                    beat_idx++;
                    if (beat_idx == frame_len()) begin
                        in_frame = 0;
                        frames_model++;
                        step_axis(box_x, dir_x, W);
                        step_axis(box_y, dir_y, H);
                        gap = 0;
                        gap_arm = sh_en;
                    end
                end
                prev_stall = bus.source_valid && !bus.source_ready;
                prev_data  = bus.source_data;
                prev_sop   = bus.source_sop;
                prev_eop   = bus.source_eop;
            end
        end
    end

    // Sink ready: always 1 or random 50 %
    initial begin
        bus.source_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.source_ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.s_chipselect = 1; bus.s_write = 1; bus.s_address = a; bus.s_writedata = d;
        case (a)
            3'd0: begin sh_en = d[0]; sh_pat = d[2:1]; sh_ctl = d[4]; end
            3'd1: sh_solid = d[23:0];
            3'd2: sh_boxcol = d[23:0];
            3'd3: begin sh_size = int'(d[7:0]); sh_step = int'(d[15:8]); end
            default: ;
        endcase
        @(negedge clk);
        bus.s_chipselect = 0; bus.s_write = 0;
    endtask

    task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.s_chipselect = 1; bus.s_read = 1; bus.s_address = a;
        @(negedge clk);
        bus.s_chipselect = 0; bus.s_read = 0;
        d = bus.s_readdata;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] req);
        logic [31:0] d;
        mm_read(a, d);
        chk_eq(name, d, req);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        sh_en = 0; sh_pat = 0; sh_ctl = 0; sh_solid = 0; sh_boxcol = 24'hFF0000; sh_size = 16; sh_step = 4;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target, c;
        target = frames_model + n;
        c = 0;
        while (frames_model < target && c < budget) begin
            @(negedge clk);
            #4;
            c++;
        end
        chk(frames_model >= target, "frame_timeout", frames_model, target);
    endtask

    task automatic wait_mid(input int idx, input int budget);
        int c;
        c = 0;
        while (!(in_frame && beat_idx >= idx) && c < budget) begin
            @(negedge clk);
            #4;
            c++;
        end
        chk(in_frame && beat_idx >= idx, "mid_frame_timeout", beat_idx, idx);
    endtask

    initial begin
        int xs [9] = '{0, 4, 8, 12, 16, 20, 24, 20, 16};
        int ys [9] = '{0, 4, 8, 12, 16, 12, 8, 4, 0};
        logic [23:0] col;
        int s;
        bus.s_chipselect = 0; bus.s_read = 0; bus.s_write = 0; bus.s_address = 0; bus.s_writedata = 0;
        bp_mode = 0; n_starts = 0; gap = 0;
        // Reset state
        do_reset();
        @(negedge clk);
        #4;
        chk_eq("rst_valid", 32'(bus.source_valid), 32'd0);
        chk_eq("rst_sop_eop", {30'b0, bus.source_sop, bus.source_eop}, 32'd0);
        chk_eq("rst_data", 32'(bus.source_data), 32'd0);
        chk_eq("rst_readdata", bus.s_readdata, 32'd0);
        read_chk("rst_ctrl", 3'd0, 32'h0);
        read_chk("rst_solid", 3'd1, 32'h0);
        read_chk("rst_boxcol", 3'd2, 32'h00FF0000);
        read_chk("rst_boxcfg", 3'd3, 32'h00000410);
        read_chk("rst_frames", 3'd4, 32'h0);
        read_chk("id", 3'd5, ID);
        read_chk("unmapped6", 3'd6, 32'h0);
        read_chk("unmapped7", 3'd7, 32'h0);

        // Colour bars with control packet, ready held high
        mm_write(3'd0, 32'h11);
        #4;
        chk_eq("start_idle_cycle", 32'(bus.source_valid), 32'd0);
        @(negedge clk);
        #4;
        chk_eq("start_first_beat", {7'b0, bus.source_valid, bus.source_data}, 32'h0100000F);
        wait_frames(1, 2000);
        chk_eq("ctl_hdr", lg_data[0], 24'h00000F);
        chk_eq("ctl_hdr_sop", 32'(lg_sop[0]), 32'd1);
        chk_eq("ctl_beat1", lg_data[1], 24'h020000);
        chk_eq("ctl_beat2", lg_data[2], 24'h000000);
        chk_eq("ctl_beat3", lg_data[3], 24'h000801);
        chk_eq("ctl_eop", 32'(lg_eop[3]), 32'd1);
        chk_eq("vid_hdr_sop", {7'b0, lg_sop[4], lg_data[4]}, 32'h01000000);
        chk_eq("bar_x0", lg_data[5], 24'hFFFFFF);
        chk_eq("bar_x4", lg_data[9], 24'hFFFF00);
        chk_eq("bar_last", lg_last, 24'h000000);
        chk_eq("eops_per_frame", lg_eops, 32'd2);
        wait_frames(1, 2000);

        // Random backpressure, same sequence
        bp_mode = 1;
        wait_frames(2, 5000);

        // Solid colour, mid-frame writes only affect following frames
        bp_mode = 0;
        wait_mid(100, 3000);
        mm_write(3'd0, 32'h03);
        wait_frames(1, 3000);
        wait_mid(100, 3000);
        mm_write(3'd1, 32'h123456);
        wait_frames(1, 3000);
        chk_eq("solid_old_first", lg_data[1], 24'h000000);
        chk_eq("solid_old_last", lg_last, 24'h000000);
        wait_frames(1, 3000);
        chk_eq("solid_new_first", lg_data[1], 24'h123456);
        chk_eq("solid_new_last", lg_last, 24'h123456);
        bp_mode = 1;
        wait_mid(100, 3000);
        col = 24'($urandom);
        mm_write(3'd1, {8'h0, col});
        wait_frames(2, 6000);
        chk_eq("solid_rand", lg_data[1], col);

        // Bouncing box from reset position
        bp_mode = 0;
        do_reset();
        col = 24'($urandom) | 24'h000001;
        mm_write(3'd3, 32'h00000408);
        mm_write(3'd2, {8'h0, col});
        mm_write(3'd0, 32'h05);
        for (int i = 0; i < 9; i++) begin
            wait_frames(1, 2000);
            chk_eq($sformatf("box_in_f%0d", i), lg_boxin, col);
            if (lg_boxout_ok) chk_eq($sformatf("box_out_f%0d", i), lg_boxout, 24'h0);
        end
        for (int i = 0; i < 9; i++) begin
            chk_eq($sformatf("box_x_f%0d", i), hist_x[i], xs[i]);
            chk_eq($sformatf("box_y_f%0d", i), hist_y[i], ys[i]);
        end
        bp_mode = 1;
        for (int i = 0; i < 3; i++) begin
            wait_mid(50, 3000);
            mm_write(3'd3, {16'h0, 8'd4, 8'($urandom_range(1, 20))});
            mm_write(3'd2, {8'h0, 24'($urandom)});
            wait_frames(1, 3000);
        end
        wait_frames(1, 3000);

        // Disable after 2.5 frames
        do_reset();
        mm_write(3'd0, 32'h01);
        wait_frames(2, 6000);
        wait_mid(W * H / 2, 3000);
        mm_write(3'd0, 32'h00);
        wait_frames(1, 3000);
        s = n_starts;
        repeat (1500) @(negedge clk);
        chk_eq("no_sop_after_disable", n_starts, s);
        read_chk("frames_after_disable", 3'd4, 32'd3);

        // Reset in the middle of the pixel stream
        bp_mode = 0;
        mm_write(3'd3, 32'h00000A06);
        mm_write(3'd0, 32'h11);
        wait_mid(300, 3000);
        do_reset();
        read_chk("mid_rst_ctrl", 3'd0, 32'h0);
        read_chk("mid_rst_boxcol", 3'd2, 32'h00FF0000);
        read_chk("mid_rst_boxcfg", 3'd3, 32'h00000410);
        read_chk("mid_rst_frames", 3'd4, 32'h0);
        mm_write(3'd0, 32'h11);
        wait_frames(1, 2000);
        chk_eq("restart_sop_hdr", {7'b0, lg_sop[0], lg_data[0]}, 32'h0100000F);
        read_chk("frames_after_restart", 3'd4, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
